ddc_chan_mux_sched: RTL and testbench

Round-robin scheduler that shares one serial sample bus between NUM_CH decimated DDC channel streams (post-DECF, e.g. I/Q pairs).
- Each channel presents single-cycle valid pulses, which are captured into a per-channel holding register.
- Grants are issued one at a time, with a configurable idle gap between output pulses.
- Each output sample is tagged with a channel index, following the codebase convention: 0 = invalid, channel n = n+1.
- Sits between the decimation filters and the channel MUX/clock-adjust stage.

---
 rtl/ddc_chan_mux_sched.sv | 162 ++++++++++++++++
 tb/tb_ddc_chan_mux_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_chan_mux_sched.sv
// Round-robin scheduler sharing one sample bus between NUM_CH decimated DDC channel streams.
// Optional build macro DDC_MUX_SCHED_PRIO_EN gives channel 0 strict priority over the rotation.
module ddc_chan_mux_sched #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 24,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Ch_Data_In,
  input  logic [NUM_CH-1:0]            Ch_Valid_In,
  input  logic [NUM_CH-1:0]            Ch_Enable,
  input  logic                         Ovr_Clr,
  output logic [DATA_WIDTH-1:0]        Data_Out,
  output logic                         Data_Out_Valid,
  output logic [3:0]                   Data_Out_ChIdx,
  output logic [NUM_CH-1:0]            Overrun_Flag
);

  // state   | meaning
  // IDLE    | waiting for a pending channel; grants on the edge one is found
  // ISSUE   | output pulse is on the bus for this cycle
  // GAP     | forced idle spacing before the next grant
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [3:0] LAST_RST = 4'(NUM_CH - 1);

  state_t                  state_q, state_d;
  logic [7:0]              gap_q, gap_d;
  logic [3:0]              last_q, last_d;
  logic [NUM_CH-1:0]       pend_q, pend_d;
  logic [NUM_CH-1:0]       ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0]   hold_q [NUM_CH];
  logic [DATA_WIDTH-1:0]   hold_d [NUM_CH];
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    dvalid_q, dvalid_d;
  logic [3:0]              chidx_q, chidx_d;

  logic                    grant_v;
  logic [3:0]              gnt;
  logic [4:0]              cand;
  logic [DATA_WIDTH-1:0]   gnt_data;

  // Reset leaves last_q at NUM_CH-1 so the rotation starts at channel 0.
  always_comb begin
    grant_v = 1'b0;
    gnt     = 4'd0;
    cand    = 5'd0;
    if (state_q == ST_IDLE && |pend_q) begin
`ifdef DDC_MUX_SCHED_PRIO_EN
      if (pend_q[0]) begin
        grant_v = 1'b1;
        gnt     = 4'd0;
      end
`endif
      for (int i = 1; i <= NUM_CH; i++) begin
        cand = {1'b0, last_q} + 5'(i);
        if (cand >= 5'(NUM_CH)) cand = cand - 5'(NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
          if (!grant_v && cand[3:0] == 4'(k) && pend_q[k]) begin
            grant_v = 1'b1;
            gnt     = 4'(k);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt == 4'(k)) gnt_data = hold_q[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    last_d   = last_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    chidx_d  = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (grant_v) begin
          dout_d   = gnt_data;
          dvalid_d = 1'b1;
          chidx_d  = gnt + 4'd1;
`ifdef DDC_MUX_SCHED_PRIO_EN
          if (gnt != 4'd0) last_d = gnt;
`else
          last_d   = gnt;
`endif
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP_CYCLES > 0) begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A capture on the granting edge keeps the channel pending and is not an overrun.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      logic cap, gk;
      cap = Ch_Valid_In[k] & Ch_Enable[k];
      gk  = grant_v && (gnt == 4'(k));
      hold_d[k] = cap ? Ch_Data_In[k*DATA_WIDTH +: DATA_WIDTH] : hold_q[k];
      if (!Ch_Enable[k]) pend_d[k] = 1'b0;
      else if (cap)      pend_d[k] = 1'b1;
      else if (gk)       pend_d[k] = 1'b0;
      else               pend_d[k] = pend_q[k];
      ovr_d[k] = (Ovr_Clr ? 1'b0 : ovr_q[k]) | (cap & pend_q[k] & ~gk);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      gap_q    <= 8'd0;
      last_q   <= LAST_RST;
      pend_q   <= '0;
      ovr_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      chidx_q  <= 4'd0;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      chidx_q  <= chidx_d;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= hold_d[k];
    end
  end

  assign Data_Out       = dout_q;
  assign Data_Out_Valid = dvalid_q;
  assign Data_Out_ChIdx = chidx_q;
  assign Overrun_Flag   = ovr_q;

endmodule

// File: tb/tb_ddc_chan_mux_sched.sv
// Scoreboard bench for ddc_chan_mux_sched: slot-based reference model feeds queues, a monitor compares.
// Honours DDC_MUX_SCHED_PRIO_EN the same way as the design.
module tb_ddc_chan_mux_sched;
  localparam int N   = 4;
  localparam int DW  = 24;
  localparam int GAP = 2;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [N*DW-1:0] Ch_Data_In = '0;
  logic [N-1:0]    Ch_Valid_In = '0;
  logic [N-1:0]    Ch_Enable = '0;
  logic            Ovr_Clr = 1'b0;
  logic [DW-1:0]   Data_Out;
  logic            Data_Out_Valid;
  logic [3:0]      Data_Out_ChIdx;
  logic [N-1:0]    Overrun_Flag;

  ddc_chan_mux_sched #(.NUM_CH(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .nRST(nRST), .Ch_Data_In(Ch_Data_In), .Ch_Valid_In(Ch_Valid_In),
    .Ch_Enable(Ch_Enable), .Ovr_Clr(Ovr_Clr), .Data_Out(Data_Out),
    .Data_Out_Valid(Data_Out_Valid), .Data_Out_ChIdx(Data_Out_ChIdx),
    .Overrun_Flag(Overrun_Flag)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; logic [DW-1:0] data; logic [3:0] idx; } exp_t;
  typedef struct { int cyc; logic [N-1:0] ovr; } ovr_t;
  exp_t q[$];
  ovr_t oq[$];

  // Reference model: a grant slot opens every 2+GAP edges; pending channels wait for a slot.
  bit [N-1:0]    m_pend;
  bit [N-1:0]    m_ovr;
  logic [DW-1:0] m_hold [N];
  int            m_last;
  int            m_free;
  int            m_gnt_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_ovr = '0;
    for (int k = 0; k < N; k++) m_hold[k] = '0;
    m_last = N - 1;
    m_free = 0;
    m_gnt_edge = -10;
    q.delete();
    oq.delete();
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Called at posedge+2; describes the upcoming edge n, then lets it happen.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] en,
                      input logic [N*DW-1:0] d, input bit clr);
    int n, g, c;
    bit [N-1:0] novr;
    exp_t e;
    ovr_t o;
    n = cyc + 1;
    g = -1;
    if (n >= m_free && m_pend != 0) begin
`ifdef DDC_MUX_SCHED_PRIO_EN
      if (m_pend[0]) g = 0;
`endif
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
`ifdef DDC_MUX_SCHED_PRIO_EN
      if (g != 0) m_last = g;
`else
      m_last = g;
`endif
      e.cyc = n; e.data = m_hold[g]; e.idx = 4'(g + 1);
      q.push_back(e);
      m_free = n + 2 + GAP;
      m_gnt_edge = n;
    end
    novr = '0;
    for (int k = 0; k < N; k++) begin
      bit cap;
      cap = v[k] && en[k];
      if (cap && m_pend[k] && g != k) novr[k] = 1'b1;
      if (!en[k])      m_pend[k] = 1'b0;
      else if (cap)    m_pend[k] = 1'b1;
      else if (g == k) m_pend[k] = 1'b0;
      if (cap) m_hold[k] = d[k*DW +: DW];
    end
    m_ovr = (clr ? '0 : m_ovr) | novr;
    o.cyc = n; o.ovr = m_ovr;
    oq.push_back(o);
    Ch_Data_In = d; Ch_Valid_In = v; Ch_Enable = en; Ovr_Clr = clr;
    @(posedge CLK); #2;
  endtask

  task automatic idle(input int cnt, input logic [N-1:0] en);
    for (int i = 0; i < cnt; i++) step('0, en, rnd_data(), 1'b0);
  endtask

  task automatic random_phase(input int cnt, input int rate);
    logic [N-1:0] v, en;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < N; k++) begin
        v[k]  = ($urandom_range(0, rate - 1) == 0);
        en[k] = ($urandom_range(0, 39) != 0);
      end
      step(v, en, rnd_data(), $urandom_range(0, 49) == 0);
    end
  endtask

  // Monitor: sampled on the falling edge, after the rising edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("missing_output_idx", 32'(0), 32'(e.idx));
        end
        if (Data_Out_Valid) begin
          if (q.size() == 0) begin
            chk("unexpected_output_idx", 32'(Data_Out_ChIdx), 32'(0));
          end else begin
            e = q.pop_front();
            chk("out_cycle", 32'(cyc), 32'(e.cyc));
            chk("out_data", 32'(Data_Out), 32'(e.data));
            chk("out_chidx", 32'(Data_Out_ChIdx), 32'(e.idx));
          end
        end else begin
          chk("idle_chidx", 32'(Data_Out_ChIdx), 32'(0));
        end
        while (oq.size() > 0 && oq[0].cyc < cyc) void'(oq.pop_front());
        if (oq.size() > 0 && oq[0].cyc == cyc)
          chk("overrun_flag", 32'(Overrun_Flag), 32'(oq[0].ovr));
      end
    end
  end

  initial begin
    logic [N*DW-1:0] d;
    bit hit;
    model_reset();
    #13;
    chk("rst_data", 32'(Data_Out), 32'(0));
    chk("rst_valid", 32'(Data_Out_Valid), 32'(0));
    chk("rst_chidx", 32'(Data_Out_ChIdx), 32'(0));
    chk("rst_ovr", 32'(Overrun_Flag), 32'(0));
    @(posedge CLK); #2;
    nRST = 1'b1;
    mon_en = 1'b1;

    idle(3, '1);
    d = rnd_data(); d[1*DW +: DW] = 24'h123456;
    step(4'b0010, '1, d, 1'b0);
    idle(8, '1);

    d = rnd_data();
    d[0*DW +: DW] = 24'h10; d[1*DW +: DW] = 24'h20;
    d[2*DW +: DW] = 24'h30; d[3*DW +: DW] = 24'h40;
    step(4'b1111, '1, d, 1'b0);
    idle(20, '1);

    d = rnd_data(); d[2*DW +: DW] = 24'hAAA;
    step(4'b0111, '1, d, 1'b0);
    d = rnd_data(); d[2*DW +: DW] = 24'hBBB;
    step(4'b0100, '1, d, 1'b0);
    idle(15, '1);
    step('0, '1, rnd_data(), 1'b1);
    idle(3, '1);

    step(4'b1001, '1, rnd_data(), 1'b0);
    step('0, 4'b0111, rnd_data(), 1'b0);
    step(4'b1000, 4'b0111, rnd_data(), 1'b0);
    idle(10, 4'b0111);
    step(4'b1000, 4'b0111, rnd_data(), 1'b0);
    idle(10, '1);

    step(4'b1110, '1, rnd_data(), 1'b0);
    for (int i = 0; i < 24; i++)
      step((i % 4 == 0) ? 4'b0001 : 4'b0000, '1, rnd_data(), 1'b0);
    idle(30, '1);

    random_phase(600, 20);

    // Async reset while a pulse is on the bus.
    step(4'b0100, '1, rnd_data(), 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (m_gnt_edge == cyc) hit = 1'b1;
      else step('0, '1, rnd_data(), 1'b0);
    end
    chk("reset_window_found", 32'(hit), 32'(1));
    mon_en = 1'b0;
    nRST = 1'b0;
    #1;
    chk("midrst_data", 32'(Data_Out), 32'(0));
    chk("midrst_valid", 32'(Data_Out_Valid), 32'(0));
    chk("midrst_chidx", 32'(Data_Out_ChIdx), 32'(0));
    chk("midrst_ovr", 32'(Overrun_Flag), 32'(0));
    model_reset();
    Ch_Valid_In = '0;
    @(posedge CLK); @(posedge CLK); #2;
    nRST = 1'b1;
    mon_en = 1'b1;
    idle(10, '1);

    random_phase(300, 6);
    idle(40, '1);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
